// File: rtl/bus_sample_fifo_if.sv
// bus_sample_fifo_if: producer/consumer handshake bundle for bus_sample_fifo
// Signals: in_valid/in_ready/in_data (producer side), out_valid/out_ready/out_data (consumer side)
// Modports: master = bench or producer/consumer side, slave = FIFO side
interface bus_sample_fifo_if #(
   parameter int X = 4
) ();
   logic         in_valid;
   logic         in_ready;
   logic [X:0]   in_data;
   logic         out_valid;
   logic         out_ready;
   logic [X:0]   out_data;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/bus_sample_fifo.sv
// bus_sample_fifo: per-instance FIFO buffering X+1-bit bus samples, with occupancy, high-water mark and stall counter
// Ports: clk, rst (sync, active-high); sif (slave modport: in_valid/in_ready/in_data, out_valid/out_ready/out_data);
//        count = occupancy, hwm = max occupancy since reset, stall_cnt = saturating in_valid & !in_ready cycles
// Optional: define BUS_SAMPLE_FIFO_DISPLAY_EN to print push and stall-start messages tagged with NAME
module bus_sample_fifo #(
   parameter int    X     = 4,
   parameter int    DEPTH = 8,
   parameter string NAME  = "DEFAULT"
) (
   input  logic                        clk,
   input  logic                        rst,
   bus_sample_fifo_if.slave            sif,
   output logic [$clog2(DEPTH+1)-1:0]  count,
   output logic [$clog2(DEPTH+1)-1:0]  hwm,
   output logic [15:0]                 stall_cnt
);
   localparam int aw = $clog2(DEPTH);
   localparam int cw = $clog2(DEPTH+1);
   localparam logic [cw-1:0] full_cnt = cw'(DEPTH);
   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
   state_t        st, st_next;
   logic [X:0]    mem [DEPTH];
   logic [aw:0]   wptr, rptr, wptr_next, rptr_next;
   logic [cw-1:0] count_next;
   logic [X:0]    head_next;
   logic          push, pop, stall;
   // pointers carry a wrap bit, so their difference is the exact occupancy for a power-of-two depth
   assign count         = wptr - rptr;
   assign sif.in_ready  = st != FULL;
   assign sif.out_valid = st != EMPTY;
   always_comb begin
      push       = sif.in_valid & sif.in_ready;
      pop        = sif.out_valid & sif.out_ready;
      stall      = sif.in_valid & ~sif.in_ready;
      wptr_next  = push ? wptr + 1 : wptr;
      rptr_next  = pop ? rptr + 1 : rptr;
      count_next = wptr_next - rptr_next;
      st_next    = count_next == '0 ? EMPTY : count_next == full_cnt ? FULL : PARTIAL;
      // the slot being written this cycle becomes the head when nothing older remains
      head_next  = push && rptr_next[aw-1:0] == wptr[aw-1:0] ? sif.in_data : mem[rptr_next[aw-1:0]];
   end
   always_ff @(posedge clk)
      if (push && !rst) mem[wptr[aw-1:0]] <= sif.in_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         hwm          <= '0;
         stall_cnt    <= '0;
         sif.out_data <= '0;
         st           <= EMPTY;
      end else begin
         wptr <= wptr_next;
         rptr <= rptr_next;
         st   <= st_next;
         if (count_next > hwm) hwm <= count_next;
         if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1;
         // out_data keeps its last value while empty
         if (count_next != '0) sif.out_data <= head_next;
      end
   end
`ifdef BUS_SAMPLE_FIFO_DISPLAY_EN
   logic stall_q;
   always_ff @(posedge clk) begin
      stall_q <= rst ? 1'b0 : stall;
      if (!rst && push) $display("bsf %s push %h count %0d", NAME, sif.in_data, count_next);
      if (!rst && stall && !stall_q) $display("bsf %s stall", NAME);
   end
`else
`endif
endmodule
